iob_pll_reset_sequencer: RTL and testbench

- Control-side counterpart to the PLL clock wizard. Drives the PLL reset input and consumes the PLL lock output.
- Runs on the free-running board reference clock, downstream of the differential input buffer. It never uses a PLL-generated clock.
- Sequences PLL reset, waits for lock with a timeout and bounded retries, debounces lock, and produces a clean system reset for logic in the generated-clock domain.

---
 rtl/iob_pll_reset_sequencer.sv | 146 ++++++++++++++
 tb/tb_iob_pll_reset_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_pll_reset_sequencer.sv
// PLL reset/lock sequencer on the reference clock: pulses PLL reset, waits for lock with
// timeout and retries, debounces lock, and gates the system reset. Option: IOB_PLL_RST_SEQ_LOSS_CNT_EN.
module iob_pll_reset_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3,
  parameter int CNT_W         = 17,
  parameter int RETRY_W       = 4
) (
  input  logic               clk_i,
  input  logic               arst_n_i,
  input  logic               pll_locked_i,
  input  logic               sw_rst_i,
  output logic               pll_rst_o,
  output logic               rst_o,
  output logic               locked_o,
  output logic               lock_fail_o,
  output logic [RETRY_W-1:0] retries_o,
  output logic [2:0]         state_o
`ifdef IOB_PLL_RST_SEQ_LOSS_CNT_EN
  ,
  output logic [7:0]         loss_cnt_o
`endif
);

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [RETRY_W-1:0] retries_d;
  logic [1:0]         sync_q;
  logic               lock_s;

  // Two-flop synchronizer; LOCKED is asynchronous to the reference clock.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) sync_q <= 2'b00;
    else           sync_q <= {sync_q[0], pll_locked_i};
  end

  assign lock_s  = sync_q[1];
  assign state_o = state;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state       <= ST_PLL_RST;
      cnt         <= '0;
      retries_o   <= '0;
      pll_rst_o   <= 1'b1;
      rst_o       <= 1'b1;
      locked_o    <= 1'b0;
      lock_fail_o <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      retries_o   <= retries_d;
      // Outputs are decoded from the next state so they line up with the state register.
      pll_rst_o   <= (state_d == ST_PLL_RST);
      rst_o       <= (state_d != ST_RUN);
      locked_o    <= (state_d == ST_RUN);
      lock_fail_o <= (state_d == ST_FAIL);
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    retries_d = retries_o;
    if (sw_rst_i) begin
      state_d   = ST_PLL_RST;
      cnt_d     = '0;
      retries_d = '0;
    end else begin
      case (state)
        ST_PLL_RST: begin
          if (cnt == CNT_W'(RST_CYCLES - 1)) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end
        ST_WAIT_LOCK: begin
          // Lock takes precedence over a timeout landing on the same edge.
          if (lock_s) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
          end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
            cnt_d = '0;
            if (retries_o == RETRY_W'(MAX_RETRIES)) begin
              state_d = ST_FAIL;
            end else begin
              state_d   = ST_PLL_RST;
              retries_d = retries_o + RETRY_W'(1);
            end
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end
        ST_STABLE: begin
          if (!lock_s) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt == CNT_W'(STABLE_CYCLES - 1)) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            state_d = ST_PLL_RST;
            cnt_d   = '0;
          end
        end
        ST_FAIL: begin
          state_d = ST_FAIL;
        end
        default: begin
          state_d = ST_PLL_RST;
          cnt_d   = '0;
        end
      endcase
    end
    if (state_d == ST_RUN) retries_d = '0;
  end

`ifdef IOB_PLL_RST_SEQ_LOSS_CNT_EN
  logic loss_event;
  // A software relock out of RUN is deliberate, not a lock loss.
  assign loss_event = (state == ST_RUN) && !lock_s && !sw_rst_i;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i)                          loss_cnt_o <= 8'd0;
    else if (loss_event && loss_cnt_o != 8'hFF) loss_cnt_o <= loss_cnt_o + 8'd1;
  end
`endif

endmodule

// File: tb/tb_iob_pll_reset_sequencer.sv
// Bench for iob_pll_reset_sequencer: phase/duration model compared every cycle,
// plus directed scenarios with hand-computed pulse widths and latencies.
module tb_iob_pll_reset_sequencer;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 20;
  localparam int STABLE_CYCLES = 8;
  localparam int MAX_RETRIES   = 2;
  localparam int CNT_W         = 17;
  localparam int RETRY_W       = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic arst_n     = 1'b0;
  logic pll_locked = 1'b0;
  logic sw_rst     = 1'b0;

  logic               pll_rst_o, rst_o, locked_o, lock_fail_o;
  logic [RETRY_W-1:0] retries_o;
  logic [2:0]         state_o;
`ifdef IOB_PLL_RST_SEQ_LOSS_CNT_EN
  logic [7:0]         loss_cnt_o;
`endif

  iob_pll_reset_sequencer #(
    .RST_CYCLES(RST_CYCLES), .LOCK_TIMEOUT(LOCK_TIMEOUT), .STABLE_CYCLES(STABLE_CYCLES),
    .MAX_RETRIES(MAX_RETRIES), .CNT_W(CNT_W), .RETRY_W(RETRY_W)
  ) dut (
    .clk_i(clk), .arst_n_i(arst_n), .pll_locked_i(pll_locked), .sw_rst_i(sw_rst),
    .pll_rst_o(pll_rst_o), .rst_o(rst_o), .locked_o(locked_o), .lock_fail_o(lock_fail_o),
    .retries_o(retries_o), .state_o(state_o)
`ifdef IOB_PLL_RST_SEQ_LOSS_CNT_EN
    , .loss_cnt_o(loss_cnt_o)
`endif
  );

  int errors = 0;
  int checks = 0;
  bit run_chk = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phases with elapsed-cycle durations; lock visibility is a 2-deep sample queue.
  typedef enum {M_RST, M_WAIT, M_STAB, M_RUN, M_FAIL} mphase_t;
  mphase_t m_phase   = M_RST;
  int      m_elapsed = 0;
  int      m_retries = 0;
  int      m_loss    = 0;
  bit      m_sync[$];

  function automatic void model_reset();
    m_phase   = M_RST;
    m_elapsed = 0;
    m_retries = 0;
    m_loss    = 0;
    m_sync.delete();
    m_sync.push_back(1'b0);
    m_sync.push_back(1'b0);
  endfunction

  function automatic void model_step();
    bit ls;
    if (m_sync.size() < 2) model_reset();
    ls = m_sync.pop_front();
    m_sync.push_back(pll_locked);
    if (sw_rst) begin
      m_phase = M_RST; m_elapsed = 0; m_retries = 0;
    end else begin
      case (m_phase)
        M_RST: begin
          m_elapsed++;
          if (m_elapsed == RST_CYCLES) begin m_phase = M_WAIT; m_elapsed = 0; end
        end
        M_WAIT: begin
          m_elapsed++;
          if (ls) begin
            m_phase = M_STAB; m_elapsed = 0;
          end else if (m_elapsed == LOCK_TIMEOUT) begin
            m_elapsed = 0;
            if (m_retries == MAX_RETRIES) m_phase = M_FAIL;
            else begin m_retries++; m_phase = M_RST; end
          end
        end
        M_STAB: begin
          if (ls) begin
            m_elapsed++;
            if (m_elapsed == STABLE_CYCLES) begin m_phase = M_RUN; m_elapsed = 0; m_retries = 0; end
          end else begin
            m_phase = M_WAIT; m_elapsed = 0;
          end
        end
        M_RUN: begin
          if (!ls) begin
            m_phase = M_RST; m_elapsed = 0;
            if (m_loss < 255) m_loss++;
          end
        end
        default: ;
      endcase
    end
  endfunction

  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) model_reset();
    else         model_step();
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (run_chk) begin
      chk("pll_rst_o", int'(pll_rst_o), int'(m_phase == M_RST));
      chk("rst_o", int'(rst_o), int'(m_phase != M_RUN));
      chk("locked_o", int'(locked_o), int'(m_phase == M_RUN));
      chk("lock_fail_o", int'(lock_fail_o), int'(m_phase == M_FAIL));
      chk("retries_o", int'(retries_o), m_retries);
`ifdef IOB_PLL_RST_SEQ_LOSS_CNT_EN
      chk("loss_cnt_o", int'(loss_cnt_o), m_loss);
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  task automatic count_pll_level(input logic lvl, output int w);
    w = 0;
    while (pll_rst_o === lvl && w < 200) begin
      w++;
      step();
    end
  endtask

  task automatic steps_until_rst(input logic val, output int n);
    n = 0;
    while (rst_o !== val && n < 300) begin
      step();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int w, n, pulses;
    bit prev;

    // Reset values while arst_n is held low.
    step(3);
    chk("reset pll_rst_o", int'(pll_rst_o), 1);
    chk("reset rst_o", int'(rst_o), 1);
    chk("reset locked_o", int'(locked_o), 0);
    chk("reset lock_fail_o", int'(lock_fail_o), 0);
    chk("reset retries_o", int'(retries_o), 0);
    run_chk = 1'b1;

    // 1. Normal lock.
    arst_n = 1'b1;
    count_pll_level(1'b1, w);
    chk("t1 pll_rst width", w, 4);
    step(6);
    pll_locked = 1'b1;
    steps_until_rst(1'b0, n);
    chk("t1 lock to release edges", n, 11);
    chk("t1 locked_o", int'(locked_o), 1);
    chk("t1 retries_o", int'(retries_o), 0);

    // 5. Lock loss in RUN.
    pll_locked = 1'b0;
    steps_until_rst(1'b1, n);
    chk("t5 loss to rst edges", n, 3);
    count_pll_level(1'b1, w);
    chk("t5 pll_rst width", w, 4);
`ifdef IOB_PLL_RST_SEQ_LOSS_CNT_EN
    chk("t5 loss_cnt_o", int'(loss_cnt_o), 1);
`endif

    // 4. Glitch at stable count 5, then release 11 edges after the lock returns.
    pll_locked = 1'b1;
    step(6);
    pll_locked = 1'b0;
    step(1);
    pll_locked = 1'b1;
    steps_until_rst(1'b0, n);
    chk("t4 relock after glitch edges", n, 11);

    // 2. Timeout retry.
    sw_rst = 1'b1;
    pll_locked = 1'b0;
    step(1);
    sw_rst = 1'b0;
    count_pll_level(1'b1, w);
    chk("t2 first pulse width", w, 4);
    count_pll_level(1'b0, w);
    chk("t2 wait_lock duration", w, 20);
    chk("t2 retries_o after timeout", int'(retries_o), 1);
    count_pll_level(1'b1, w);
    chk("t2 second pulse width", w, 4);
    pll_locked = 1'b1;
    steps_until_rst(1'b0, n);
    chk("t2 release edges", n, 11);
    chk("t2 retries_o in run", int'(retries_o), 0);
`ifdef IOB_PLL_RST_SEQ_LOSS_CNT_EN
    chk("t2 sw_rst not counted", int'(loss_cnt_o), 1);
`endif

    // 3. Lock failure after three attempts, then software relock.
    sw_rst = 1'b1;
    pll_locked = 1'b0;
    step(1);
    sw_rst = 1'b0;
    pulses = 0;
    prev = 1'b0;
    n = 0;
    while (lock_fail_o !== 1'b1 && n < 300) begin
      if (pll_rst_o && !prev) pulses++;
      prev = pll_rst_o;
      step();
      n++;
    end
    chk("t3 pulse count", pulses, 3);
    chk("t3 lock_fail_o", int'(lock_fail_o), 1);
    chk("t3 rst_o", int'(rst_o), 1);
    chk("t3 retries_o", int'(retries_o), 2);
    step(5);
    chk("t3 fail is terminal", int'(lock_fail_o), 1);
    sw_rst = 1'b1;
    step(1);
    sw_rst = 1'b0;
    chk("t3 sw clears lock_fail_o", int'(lock_fail_o), 0);
    chk("t3 sw starts pulse", int'(pll_rst_o), 1);
    chk("t3 sw clears retries_o", int'(retries_o), 0);

    // 6. Asynchronous reset in STABLE.
    count_pll_level(1'b1, w);
    chk("t6 pulse width", w, 4);
    pll_locked = 1'b1;
    step(5);
    arst_n = 1'b0;
    #1;
    chk("t6 async pll_rst_o", int'(pll_rst_o), 1);
    chk("t6 async rst_o", int'(rst_o), 1);
    chk("t6 async retries_o", int'(retries_o), 0);
    chk("t6 async locked_o", int'(locked_o), 0);
`ifdef IOB_PLL_RST_SEQ_LOSS_CNT_EN
    chk("t6 async loss_cnt_o", int'(loss_cnt_o), 0);
`endif
    step(2);
    arst_n = 1'b1;
    count_pll_level(1'b1, w);
    chk("t6 pulse after release", w, 4);
    steps_until_rst(1'b0, n);
    chk("t6 relock edges", n, 9);
    step(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
